// File: rtl/tsc1_pkg.sv
// Shared defaults and the data-word type for the TSC1 register-file block.
package tsc1_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;

    typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/tsc1_regfile.sv
// Flop-based storage array with write decode and synchronous clear.
module tsc1_regfile
    import tsc1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DEPTH*DATA_W-1:0]  o_mem
);

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;

    // Per-entry decode keeps storage as plain flops; reset wins over any write.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_reset) begin
                r_mem[i] <= '0;
            end else if (i_we && (i_addr == ADDR_W'(i))) begin
                r_mem[i] <= i_wdata;
            end
        end
    end

    assign o_mem = r_mem;

endmodule

// File: rtl/tsc1.sv
// TSC1 top: storage instance, read mux, write-first bypass and read_data register.
module tsc1
    import tsc1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
        $error("tsc1: ADDR_W must equal clog2(DEPTH)");
    end

    logic [DEPTH*DATA_W-1:0] w_mem;
    logic [DATA_W-1:0]       w_rd_entry;
    logic [DATA_W-1:0]       w_rd_next;
    logic [DATA_W-1:0]       r_read_data;

    tsc1_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .i_clk   (clk),
        .i_reset (reset),
        .i_we    (write_enable),
        .i_addr  (write_address),
        .i_wdata (write_data),
        .o_mem   (w_mem)
    );

    assign w_rd_entry = w_mem[write_address*DATA_W +: DATA_W];

    // Same-address write lands in read_data on the same edge (write-first).
    assign w_rd_next = write_enable ? write_data : w_rd_entry;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data <= '0;
        end else begin
            r_read_data <= w_rd_next;
        end
    end

    assign read_data = r_read_data;

endmodule

// File: tb/tb_tsc1.sv
// Directed, table-driven bench for tsc1: each vector is one clock edge plus its expected read_data.
module tb_tsc1;
    import tsc1_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  write_enable;
    logic [ADDR_W_DEF-1:0] write_address;
    word_t                 write_data;
    word_t                 read_data;

    int checks   = 0;
    int failures = 0;

    tsc1 dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .read_data     (read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                 tag;
        logic                  rst;
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        word_t                 wd;
        word_t                 exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string tag, logic rst, logic we,
                                logic [ADDR_W_DEF-1:0] addr, word_t wd, word_t exp);
        vec_t v;
        v.tag  = tag;
        v.rst  = rst;
        v.we   = we;
        v.addr = addr;
        v.wd   = wd;
        v.exp  = exp;
        vecs.push_back(v);
    endfunction

    // Drive on the falling edge, let one rising edge pass, compare 1 time unit later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset         = v.rst;
        write_enable  = v.we;
        write_address = v.addr;
        write_data    = v.wd;
        @(posedge clk);
        #1;
        checks++;
        if (read_data !== v.exp) begin
            failures++;
            $display("FAIL %s addr=%0d: read_data=%02h expected=%02h",
                     v.tag, v.addr, read_data, v.exp);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic we,
                        input logic [ADDR_W_DEF-1:0] addr, input word_t wd, input word_t exp);
        vec_t v;
        v.tag  = tag;
        v.rst  = rst;
        v.we   = we;
        v.addr = addr;
        v.wd   = wd;
        v.exp  = exp;
        apply(v);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        write_enable  = 1'b0;
        write_address = '0;
        write_data    = '0;

        // Reset edge with a coinciding write that must be discarded, then all entries read 00.
        add("reset_rd", 1'b1, 1'b1, 4'd0, 8'h55, 8'h00);
        for (int i = 0; i < 16; i++)
            add("reset_mem", 1'b0, 1'b0, 4'(i), 8'h00, 8'h00);

        // FF into address 0, then hold address 0 with write_enable low.
        add("wr_ff", 1'b0, 1'b1, 4'd0, 8'hFF, 8'hFF);
        add("hold_ff", 1'b0, 1'b0, 4'd0, 8'h00, 8'hFF);
        add("hold_ff", 1'b0, 1'b0, 4'd0, 8'h12, 8'hFF);

        // Same-edge write and read at address 3.
        add("wr_first", 1'b0, 1'b1, 4'd3, 8'hA5, 8'hA5);
        add("rd_a5", 1'b0, 1'b0, 4'd3, 8'h00, 8'hA5);
        add("rd_other", 1'b0, 1'b0, 4'd1, 8'h00, 8'h00);

        // Back-to-back writes of address+10 to every entry, then read 15 down to 0.
        for (int i = 0; i < 16; i++)
            add("wr_all", 1'b0, 1'b1, 4'(i), word_t'(i + 10), word_t'(i + 10));
        for (int i = 15; i >= 0; i--)
            add("rd_all", 1'b0, 1'b0, 4'(i), 8'h00, word_t'(i + 10));

        // write_enable low with 77 on the data bus: nothing changes.
        for (int i = 0; i < 16; i++)
            add("no_we", 1'b0, 1'b0, 4'(i), 8'h77, word_t'(i + 10));

        foreach (vecs[k]) apply(vecs[k]);

        // Reset mid-operation while writing, then immediate resumption.
        step("wr_3c", 1'b0, 1'b1, 4'd7, 8'h3C, 8'h3C);
        step("rd_3c", 1'b0, 1'b0, 4'd7, 8'h00, 8'h3C);
        step("rst_wr", 1'b1, 1'b1, 4'd7, 8'h99, 8'h00);
        step("rst_clr7", 1'b0, 1'b0, 4'd7, 8'h00, 8'h00);
        step("rst_clr3", 1'b0, 1'b0, 4'd3, 8'h00, 8'h00);
        step("rst_clrf", 1'b0, 1'b0, 4'd15, 8'h00, 8'h00);
        step("rst_wr2", 1'b1, 1'b1, 4'd5, 8'h44, 8'h00);
        step("post_wr", 1'b0, 1'b1, 4'd5, 8'h12, 8'h12);
        step("post_rd", 1'b0, 1'b0, 4'd5, 8'h00, 8'h12);
        step("post_nb", 1'b0, 1'b0, 4'd6, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
